// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the three-requester single-port memory arbiter:
// controller states, requester ids and the id-to-one-hot helper.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ID_IF   = 2'd0,
        ID_LS   = 2'd1,
        ID_HOST = 2'd2
    } req_id_e;

    // Bit order of every one-hot vector: [0]=fetch, [1]=load-store, [2]=host
    function automatic logic [2:0] id_onehot(input req_id_e id);
        logic [2:0] v;
        case (id)
            ID_IF:   v = 3'b001;
            ID_LS:   v = 3'b010;
            ID_HOST: v = 3'b100;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes and the single memory port seen by the arbiter.
interface mem_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;

    logic          ls_req;
    logic          ls_we;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic          ls_gnt;
    logic          ls_rvalid;

    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt;
    logic          host_rvalid;

    logic [DW-1:0] rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        input  ls_req, ls_we, ls_addr, ls_wdata,
        input  host_req, host_we, host_addr, host_wdata,
        input  mem_rdata,
        output if_gnt, if_rvalid, ls_gnt, ls_rvalid, host_gnt, host_rvalid,
        output rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr,
        output ls_req, ls_we, ls_addr, ls_wdata,
        output host_req, host_we, host_addr, host_wdata,
        output mem_rdata,
        input  if_gnt, if_rvalid, ls_gnt, ls_rvalid, host_gnt, host_rvalid,
        input  rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_arb_prio_starve.sv
// Fixed-priority select (host > ls > fetch) with a saturating fetch-starvation
// counter that hands the port to fetch once it has lost STARVE_LIMIT times in a row.
module arb_prio_starve
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    i_arb,
    input  logic    i_if_req,
    input  logic    i_ls_req,
    input  logic    i_host_req,
    output req_id_e o_win_id
);

    localparam int             CW      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]  LIMIT_C = CW'(STARVE_LIMIT);

    logic [CW-1:0] r_cnt;
    logic          w_starved;
    req_id_e       w_win_id;

    assign w_starved = (r_cnt == LIMIT_C);

    // Winner selection, starvation override first
    always_comb begin
        w_win_id = ID_IF;
        if (i_if_req && w_starved) begin
            w_win_id = ID_IF;
        end else if (i_host_req) begin
            w_win_id = ID_HOST;
        end else if (i_ls_req) begin
            w_win_id = ID_LS;
        end else begin
            w_win_id = ID_IF;
        end
    end

    // Starvation counter, updated only on arbitration edges
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= {CW{1'b0}};
        end else if (i_arb) begin
            if (i_if_req && (w_win_id != ID_IF)) begin
                r_cnt <= w_starved ? r_cnt : (r_cnt + CW'(1));
            end else begin
                r_cnt <= {CW{1'b0}};
            end
        end
    end

    assign o_win_id = w_win_id;

endmodule

// File: rtl/mem_port_arbiter.sv
// Three-requester arbiter for a single synchronous-read memory port:
// IDLE/ACCESS/RESP controller, latched winner request and read-valid routing.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW           = 16,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);

    state_e        r_state;
    state_e        w_state_nxt;
    logic          w_arb;
    logic          w_any_req;
    logic          w_access;
    req_id_e       w_win_id;
    req_id_e       r_win_id;
    logic [AW-1:0] r_addr;
    logic          r_we;
    logic [DW-1:0] r_wdata;
    logic [2:0]    r_rvalid;
    logic [2:0]    w_gnt;

    assign w_any_req = bus.if_req | bus.ls_req | bus.host_req;
    assign w_access  = (r_state == ST_ACCESS);

    arb_prio_starve #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk        (clk),
        .reset      (reset),
        .i_arb      (w_arb),
        .i_if_req   (bus.if_req),
        .i_ls_req   (bus.ls_req),
        .i_host_req (bus.host_req),
        .o_win_id   (w_win_id)
    );

    // Next-state and arbitration-edge decode
    always_comb begin
        w_state_nxt = r_state;
        w_arb       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_ACCESS;
                    w_arb       = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (w_any_req) begin
                    w_state_nxt = ST_ACCESS;
                    w_arb       = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the winning request; fetch is always a read
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_win_id <= ID_IF;
            r_addr   <= {AW{1'b0}};
            r_we     <= 1'b0;
            r_wdata  <= {DW{1'b0}};
        end else if (w_arb) begin
            r_win_id <= w_win_id;
            case (w_win_id)
                ID_HOST: begin
                    r_addr  <= bus.host_addr;
                    r_we    <= bus.host_we;
                    r_wdata <= bus.host_wdata;
                end
                ID_LS: begin
                    r_addr  <= bus.ls_addr;
                    r_we    <= bus.ls_we;
                    r_wdata <= bus.ls_wdata;
                end
                ID_IF: begin
                    r_addr  <= bus.if_addr;
                    r_we    <= 1'b0;
                    r_wdata <= {DW{1'b0}};
                end
                default: begin
                    r_addr  <= {AW{1'b0}};
                    r_we    <= 1'b0;
                    r_wdata <= {DW{1'b0}};
                end
            endcase
        end
    end

    // Read-valid is raised for the cycle in which the memory returns data
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rvalid <= 3'b000;
        end else if (w_access && !r_we) begin
            r_rvalid <= id_onehot(r_win_id);
        end else begin
            r_rvalid <= 3'b000;
        end
    end

    assign w_gnt = w_access ? id_onehot(r_win_id) : 3'b000;

    assign bus.if_gnt      = w_gnt[0];
    assign bus.ls_gnt      = w_gnt[1];
    assign bus.host_gnt    = w_gnt[2];
    assign bus.if_rvalid   = r_rvalid[0];
    assign bus.ls_rvalid   = r_rvalid[1];
    assign bus.host_rvalid = r_rvalid[2];

    assign bus.mem_en    = w_access;
    assign bus.mem_we    = w_access & r_we;
    assign bus.mem_addr  = w_access ? r_addr  : {AW{1'b0}};
    assign bus.mem_wdata = w_access ? r_wdata : {DW{1'b0}};
    assign bus.rdata     = (|r_rvalid) ? bus.mem_rdata : {DW{1'b0}};

endmodule
